// File: rtl/f_mon_pkg.sv
// Shared types and constants for the f-stream pattern monitor.
package f_mon_pkg;

    // Prefix progress towards the 1-1-0-1 pattern
    typedef enum logic [1:0] {
        S0   = 2'd0,
        S1   = 2'd1,
        S11  = 2'd2,
        S110 = 2'd3
    } pat_state_t;

    // Detected bit pattern, oldest bit in the MSB
    localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous zero (priority over inc) and an
// overflow pulse when an increment is requested while already all-ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         zero,
    output logic [W-1:0] q,
    output logic         ovf
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next count: zero wins, otherwise increment until all-ones
    always_comb begin
        q_d = q_q;
        ovf = 1'b0;
        if (zero) begin
            q_d = '0;
        end else if (inc) begin
            if (&q_q) begin
                ovf = 1'b1;
            end else begin
                q_d = q_q + W'(1);
            end
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/f_pattern_detect.sv
// Monitors the qualified f bit stream: detects overlapping 1-1-0-1 matches
// and keeps saturating match / run-length statistics.
module f_pattern_detect
    import f_mon_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_in,
    input  logic             f_vld,
    input  logic             clr,
    output logic             det,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] max_run,
    output logic             sat
);

    pat_state_t       state_q;
    pat_state_t       state_d;
    logic             det_q;
    logic             det_d;
    logic [CNT_W-1:0] max_run_q;
    logic [CNT_W-1:0] max_run_d;
    logic             sat_q;
    logic             sat_d;

    logic             take;
    logic             match;
    logic             run_inc;
    logic             run_zero;
    logic             match_ovf;
    logic             run_ovf;
    logic [CNT_W-1:0] run_nxt;

    // Sample qualification; clr discards a coincident sample
    assign take     = f_vld & ~clr;
    assign match    = take & f_in & (state_q == S110);
    assign run_inc  = take & f_in;
    assign run_zero = clr | (take & ~f_in);

    // Pattern FSM next state
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = S0;
        end else if (f_vld) begin
            case (state_q)
                S0:      state_d = f_in ? S1  : S0;
                S1:      state_d = f_in ? S11 : S0;
                S11:     state_d = f_in ? S11 : S110;
                S110:    state_d = f_in ? S1  : S0;
                default: state_d = S0;
            endcase
        end
    end

    // Match pulse, running maximum and sticky saturation flag
    always_comb begin
        det_d     = match;
        run_nxt   = run_len;
        max_run_d = max_run_q;
        sat_d     = sat_q | match_ovf | run_ovf;
        if (run_zero) begin
            run_nxt = '0;
        end else if (run_inc && !(&run_len)) begin
            run_nxt = run_len + CNT_W'(1);
        end
        if (clr) begin
            max_run_d = '0;
            sat_d     = 1'b0;
        end else if (run_nxt > max_run_q) begin
            max_run_d = run_nxt;
        end
    end

    // FSM and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S0;
            det_q     <= 1'b0;
            max_run_q <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            det_q     <= det_d;
            max_run_q <= max_run_d;
            sat_q     <= sat_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (match),
        .zero (clr),
        .q    (match_cnt),
        .ovf  (match_ovf)
    );

    sat_counter #(.W(CNT_W)) u_run_len (
        .clk  (clk),
        .rst  (rst),
        .inc  (run_inc),
        .zero (run_zero),
        .q    (run_len),
        .ovf  (run_ovf)
    );

    assign det     = det_q;
    assign max_run = max_run_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_f_pattern_detect.sv
// Self-checking bench for f_pattern_detect (CNT_W = 3 to reach saturation).
module tb_f_pattern_detect;
    import f_mon_pkg::*;

    localparam int unsigned W   = 3;
    localparam int          LIM = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         f_in;
    logic         f_vld;
    logic         clr;
    logic         det;
    logic [W-1:0] match_cnt;
    logic [W-1:0] run_len;
    logic [W-1:0] max_run;
    logic         sat;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: last four valid bits since clear and unbounded counts
    logic [3:0] m_hist;
    int         m_nb;
    int         m_matches;
    int         m_run;
    int         m_maxrun;
    logic       m_sat;
    logic       m_det;

    typedef struct {
        logic v;
        logic b;
        logic c;
        logic e_det;
        int   e_cnt;
        int   e_run;
        int   e_max;
        logic e_sat;
    } vec_t;

    f_pattern_detect #(.CNT_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .f_in      (f_in),
        .f_vld     (f_vld),
        .clr       (clr),
        .det       (det),
        .match_cnt (match_cnt),
        .run_len   (run_len),
        .max_run   (max_run),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    function automatic int sat_val(input int x);
        return (x > LIM) ? LIM : x;
    endfunction

    task automatic model_clear();
        m_hist    = 4'b0;
        m_nb      = 0;
        m_matches = 0;
        m_run     = 0;
        m_maxrun  = 0;
        m_sat     = 1'b0;
        m_det     = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic b, input logic c);
        if (c) begin
            model_clear();
        end else if (v) begin
            m_hist = {m_hist[2:0], b};
            if (m_nb < 4) m_nb++;
            m_det = (m_nb >= 4) && (m_hist == PATTERN);
            if (m_det) m_matches++;
            m_run = b ? m_run + 1 : 0;
            if (m_run > m_maxrun) m_maxrun = m_run;
            if (m_matches > LIM || m_run > LIM) m_sat = 1'b1;
        end else begin
            m_det = 1'b0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("det", int'(det), int'(m_det));
        chk("match_cnt", int'(match_cnt), sat_val(m_matches));
        chk("run_len", int'(run_len), sat_val(m_run));
        chk("max_run", int'(max_run), sat_val(m_maxrun));
        chk("sat", int'(sat), int'(m_sat));
    endtask

    // Apply one cycle of inputs, advance the model, sample after the edge
    task automatic step(input logic v, input logic b, input logic c);
        f_vld = v;
        f_in  = b;
        clr   = c;
        @(posedge clk);
        model_step(v, b, c);
        #1;
    endtask

    task automatic bits(input logic [15:0] pat, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, pat[i], 1'b0);
            check_model();
        end
    endtask

    vec_t vecs[$];

    initial begin
        // Basic overlap, clr override, then near misses
        vecs.push_back('{1, 1, 0, 0, 0, 1, 1, 0});
        vecs.push_back('{1, 1, 0, 0, 0, 2, 2, 0});
        vecs.push_back('{1, 0, 0, 0, 0, 0, 2, 0});
        vecs.push_back('{1, 1, 0, 1, 1, 1, 2, 0});
        vecs.push_back('{1, 1, 0, 0, 1, 2, 2, 0});
        vecs.push_back('{1, 0, 0, 0, 1, 0, 2, 0});
        vecs.push_back('{1, 1, 0, 1, 2, 1, 2, 0});
        vecs.push_back('{1, 1, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 1, 0, 0, 0, 1, 1, 0});
        vecs.push_back('{1, 1, 0, 0, 0, 2, 2, 0});
        vecs.push_back('{1, 1, 0, 0, 0, 3, 3, 0});
        vecs.push_back('{1, 0, 0, 0, 0, 0, 3, 0});
        vecs.push_back('{1, 0, 0, 0, 0, 0, 3, 0});
        vecs.push_back('{1, 1, 0, 0, 0, 1, 3, 0});
        vecs.push_back('{1, 0, 0, 0, 0, 0, 3, 0});
        vecs.push_back('{1, 1, 0, 0, 0, 1, 3, 0});

        rst   = 1'b1;
        f_in  = 1'b0;
        f_vld = 1'b0;
        clr   = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_det", int'(det), 0);
        chk("reset_cnt", int'(match_cnt), 0);
        chk("reset_run", int'(run_len), 0);
        chk("reset_max", int'(max_run), 0);
        chk("reset_sat", int'(sat), 0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven directed vectors
        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].b, vecs[i].c);
            chk($sformatf("tbl%0d_det", i), int'(det), int'(vecs[i].e_det));
            chk($sformatf("tbl%0d_cnt", i), int'(match_cnt), vecs[i].e_cnt);
            chk($sformatf("tbl%0d_run", i), int'(run_len), vecs[i].e_run);
            chk($sformatf("tbl%0d_max", i), int'(max_run), vecs[i].e_max);
            chk($sformatf("tbl%0d_sat", i), int'(sat), int'(vecs[i].e_sat));
        end

        // Gaps of three invalid cycles between pattern bits
        step(1'b0, 1'b0, 1'b1);
        for (int k = 3; k >= 0; k--) begin
            step(1'b1, PATTERN[k], 1'b0);
            check_model();
            if (k != 0) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, ~PATTERN[k], 1'b0);
                    check_model();
                end
            end
        end
        chk("gap_det", int'(det), 1);
        chk("gap_cnt", int'(match_cnt), 1);
        step(1'b0, 1'b1, 1'b0);
        chk("gap_det_drop", int'(det), 0);

        // Nine consecutive overlapping matches saturate match_cnt
        step(1'b0, 1'b0, 1'b1);
        bits(16'h000D, 4);
        for (int k = 0; k < 8; k++) bits(16'h0005, 3);
        chk("sat_cnt", int'(match_cnt), 7);
        chk("sat_cnt_flag", int'(sat), 1);

        // Ten valid ones saturate run_len and max_run
        step(1'b0, 1'b0, 1'b1);
        chk("clr_sat", int'(sat), 0);
        bits(16'h03FF, 10);
        chk("sat_run", int'(run_len), 7);
        chk("sat_max", int'(max_run), 7);
        chk("sat_run_flag", int'(sat), 1);

        // clr with a completing bit while in S110
        step(1'b0, 1'b0, 1'b1);
        bits(16'h0006, 3);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_det", int'(det), 0);
        chk("clr_cnt", int'(match_cnt), 0);
        chk("clr_run", int'(run_len), 0);
        chk("clr_max", int'(max_run), 0);
        bits(16'h0001, 1);
        chk("clr_fsm_s0", int'(det), 0);

        // Asynchronous reset mid-pattern
        step(1'b0, 1'b0, 1'b1);
        bits(16'h0006, 3);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        chk("arst_run", int'(run_len), 0);
        chk("arst_max", int'(max_run), 0);
        chk("arst_det", int'(det), 0);
        @(negedge clk);
        rst = 1'b0;
        bits(16'h0001, 1);
        chk("arst_no_det", int'(det), 0);
        chk("arst_no_cnt", int'(match_cnt), 0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 99) < 65),
                 ($urandom_range(0, 31) == 0));
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/f_pattern_detect.md
# f_pattern_detect

Downstream monitor for the registered 1-bit `f` output of `and_or_reg`. It samples `f` on qualified cycles and runs a 4-state FSM that detects the overlapping bit pattern 1-1-0-1, emitting a one-cycle `det` pulse per match. It also keeps saturating statistics: match count, current run of consecutive ones, and longest run. Statistics are read by the status/debug logic in the same clock domain.

## Interface
Parameters:
- `CNT_W`, default 8: width of `match_cnt`, `run_len` and `max_run`. Minimum 2.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `f_in`  in  1: sampled data bit; connects to `and_or_reg.f`.
- `f_vld`  in  1: sample qualifier; `f_in` is consumed only when high. Tie to 1 for every-cycle sampling.
- `clr`  in  1: synchronous clear of FSM and all statistics.
- `det`  out  1: one-cycle pulse; pattern completed on the previous sampled bit.
- `match_cnt`  out  CNT_W: number of matches, saturating.
- `run_len`  out  CNT_W: current count of consecutive sampled ones, saturating.
- `max_run`  out  CNT_W: largest `run_len` since reset or clear.
- `sat`  out  1: sticky flag; set when any counter would exceed 2^CNT_W−1.

## Operation
- FSM states encode prefix progress:
  - S0 = none.
  - S1 = "1".
  - S11 = "11".
  - S110 = "110".
- Transitions occur only on cycles with `f_vld` = 1 (bit b = `f_in`):
  - S0: b=1 → S1; b=0 → S0.
  - S1: b=1 → S11; b=0 → S0.
  - S11: b=1 → S11; b=0 → S110.
  - S110: b=1 → S1 and register a match; b=0 → S0.
- Overlap: a match returns to S1, so input 1101101 yields two matches.
- Match behaviour: `det` = 1 for exactly the next cycle; `match_cnt` += 1 unless already all-ones. At all-ones, `match_cnt` holds and `sat` is set.
- Run length:
  - Valid 1: `run_len` += 1, saturating at all-ones; saturating also sets `sat`.
  - Valid 0: `run_len` ← 0.
  - Max tracking: `max_run` ← max(`max_run`, next `run_len`) on the same edge, so `max_run` never lags `run_len`.
- `f_vld` = 0: FSM, counters and `sat` hold, and `det` = 0. Gaps do not break a pattern in progress.
- `clr` = 1: on the next edge FSM ← S0, all counters ← 0, `sat` ← 0, `det` ← 0. `clr` overrides a simultaneous `f_vld`, and that sample is discarded.
- Arithmetic is unsigned throughout, and counters never wrap.

## Timing
- Reset values: FSM = S0; `det` = 0, `match_cnt` = 0, `run_len` = 0, `max_run` = 0, `sat` = 0.
- Reset mid-pattern abandons the partial match, and no `det` follows.
- Latency: all outputs are registered, one edge after the sampling edge. For a fourth pattern bit sampled at edge N, `det` is high from edge N until edge N+1, and `match_cnt` shows the new value from edge N.
- Maximum `det` rate: one pulse per 3 valid samples (pattern 1101101...), so `det` is never high on two consecutive cycles.
- No combinational path from any input to any output.
- Upstream `and_or_reg.f` is already registered; no input synchronisation is required.

## Structure
- Package `f_mon_pkg`:
  - `typedef enum logic [1:0] {S0, S1, S11, S110} pat_state_t`.
  - Localparam `PATTERN = 4'b1101`, for documentation and bench reference.
- Sub-module `sat_counter` (parameter W; inputs `inc`, `zero`; outputs `q`, `ovf`):
  - `zero` has priority over `inc`.
  - `ovf` pulses when `inc` is applied at all-ones.
  - Instantiated for `match_cnt` and `run_len`.
- FSM, `det` register, `max_run` compare and `sat` flag live in the top module.

## Test plan
- Basic overlap: `f_vld` = 1, `f_in` = 1,1,0,1,1,0,1 → `det` pulses on the cycles after samples 4 and 7; `match_cnt` = 2; `max_run` = 2.
- Near misses: `f_in` = 1,1,1,0,0,1,0,1 → no `det`; `max_run` = 3; final `run_len` = 1.
- Gaps: bits 1,1,0,1 with `f_vld` low for 3 cycles between each bit → one `det` pulse after the final valid bit; FSM holds during gaps.
- Saturation, with CNT_W = 3:
  - 9 consecutive matches → `match_cnt` stops at 7 and `sat` = 1.
  - 10 consecutive valid ones → `run_len` = 7 and `max_run` = 7.
- Clear/reset priority:
  - `clr` with `f_vld` = 1, `f_in` = 1 while in S110 → no `det`; all counters 0; FSM S0.
  - Async `rst` mid-pattern (after 1,1,0) → outputs 0 immediately; a following 1 produces no match.
